torpedo_scheduler: RTL and testbench

Allocates the torpedo slots for the ship's weapon. It turns the fire button into one-cycle launch pulses aimed at the lowest-numbered free torpedo unit. It enforces a refire cooldown and optional hold-to-autofire, and tracks each slot's flight lifetime in frames. It sits between `periphery_control` (button A), the frame-pulse generator, and the `Torpedo_Unit` instances, replacing the cascaded fire chain with a central arbiter.

---
 rtl/torpedo_scheduler.sv | 170 +++++++++++++++++
 tb/tb_torpedo_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/torpedo_scheduler.sv
// torpedo_scheduler
// Central arbiter for the ship's torpedo slots. It turns the fire button into
// one-cycle launch pulses aimed at the lowest free slot, enforces a refire
// cooldown, supports hold-to-autofire, and counts each slot's flight lifetime
// in frames.
//
// Ports:
//   clk       - pixel clock
//   resetN    - synchronous, active-low reset
//   enable    - game running; gates new requests only
//   fire      - fire button level (already synchronised)
//   vsync     - one-cycle frame pulse
//   hit       - per-slot release pulse
//   launch    - one-hot, one-cycle launch pulse per slot
//   active    - slot in flight
//   free_cnt  - number of slots not in flight
//   denied    - one-cycle pulse when a request is refused
module torpedo_scheduler #(
  parameter int unsigned T_NUM           = 4,
  parameter int unsigned LIFE_FRAMES     = 90,
  parameter int unsigned COOLDOWN_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 10
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         enable,
  input  logic                         fire,
  input  logic                         vsync,
  input  logic [T_NUM-1:0]             hit,
  output logic [T_NUM-1:0]             launch,
  output logic [T_NUM-1:0]             active,
  output logic [$clog2(T_NUM+1)-1:0]   free_cnt,
  output logic                         denied
);

  localparam int unsigned FW = $clog2(T_NUM + 1);
  localparam int unsigned LW = $clog2(LIFE_FRAMES + 1);
  localparam int unsigned CW = (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int unsigned RW = (REPEAT_FRAMES == 0) ? 1 : $clog2(REPEAT_FRAMES + 1);

  logic             fire_d_q;
  logic             req_q, req_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic [CW-1:0]    cool_q, cool_d, cool_eff;
  logic [LW-1:0]    life_q [T_NUM];
  logic [LW-1:0]    life_d [T_NUM];
  logic [T_NUM-1:0] active_q, active_d;
  logic [T_NUM-1:0] launch_q, launch_d;
  logic [T_NUM-1:0] pick;
  logic             pick_found;
  logic             denied_q, denied_d;
  logic [FW-1:0]    free_q, free_d;

  assign launch   = launch_q;
  assign active   = active_q;
  assign free_cnt = free_q;
  assign denied   = denied_q;

  // Request generation: rising edge fires at once, holding fire repeats every
  // REPEAT_FRAMES frames; releasing fire clears the repeat counter.
  always_comb begin
    req_d = 1'b0;
    rpt_d = rpt_q;
    if (!fire) begin
      rpt_d = '0;
    end else if (enable && !fire_d_q) begin
      req_d = 1'b1;
      rpt_d = RW'(REPEAT_FRAMES);
    end else if (enable && vsync && (REPEAT_FRAMES != 0)) begin
      if (rpt_q == RW'(1)) begin
        req_d = 1'b1;
        rpt_d = RW'(REPEAT_FRAMES);
      end else if (rpt_q != '0) begin
        rpt_d = rpt_q - RW'(1);
      end
    end
  end

  // Lowest-index free slot, taken from the registered active vector so a slot
  // being released this cycle is never targeted.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < T_NUM; i++) begin
      if (!active_q[i] && !pick_found) begin
        pick[i]    = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  // Cooldown decrement is applied before the readiness check.
  assign cool_eff = (vsync && (cool_q != '0)) ? (cool_q - CW'(1)) : cool_q;

  // Slot lifetimes, arbitration and free count.
  always_comb begin
    active_d = active_q;
    life_d   = life_q;
    launch_d = '0;
    denied_d = 1'b0;
    cool_d   = cool_eff;
    free_d   = '0;

    for (int i = 0; i < T_NUM; i++) begin
      if (active_q[i]) begin
        if (hit[i]) begin
          active_d[i] = 1'b0;
          life_d[i]   = '0;
        end else if (vsync) begin
          if (life_q[i] == LW'(1)) begin
            active_d[i] = 1'b0;
            life_d[i]   = '0;
          end else begin
            life_d[i] = life_q[i] - LW'(1);
          end
        end
      end
    end

    // A request arriving after enable has fallen is dropped without denial.
    if (req_q && enable) begin
      if ((cool_eff == '0) && pick_found) begin
        launch_d = pick;
        active_d = active_d | pick;
        cool_d   = CW'(COOLDOWN_FRAMES);
        for (int i = 0; i < T_NUM; i++) begin
          if (pick[i]) begin
            life_d[i] = LW'(LIFE_FRAMES);
          end
        end
      end else begin
        denied_d = 1'b1;
      end
    end

    for (int i = 0; i < T_NUM; i++) begin
      if (!active_d[i]) begin
        free_d = free_d + FW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fire_d_q <= 1'b0;
      req_q    <= 1'b0;
      rpt_q    <= '0;
      cool_q   <= '0;
      active_q <= '0;
      launch_q <= '0;
      denied_q <= 1'b0;
      free_q   <= FW'(T_NUM);
      for (int i = 0; i < T_NUM; i++) begin
        life_q[i] <= '0;
      end
    end else begin
      fire_d_q <= fire;
      req_q    <= req_d;
      rpt_q    <= rpt_d;
      cool_q   <= cool_d;
      active_q <= active_d;
      launch_q <= launch_d;
      denied_q <= denied_d;
      free_q   <= free_d;
      life_q   <= life_d;
    end
  end

endmodule

// File: tb/tb_torpedo_scheduler.sv
// tb_torpedo_scheduler
// Directed bench for torpedo_scheduler with a frame-level reference model and
// hand-computed literal expectations at key points of each scenario.
module tb_torpedo_scheduler;

  localparam int T     = 4;
  localparam int LIFE  = 90;
  localparam int COOL  = 4;
  localparam int REP   = 10;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       resetN, enable, fire, vsync;
  logic [3:0] hit;
  logic [3:0] launch, active;
  logic [2:0] free_cnt;
  logic       denied;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  torpedo_scheduler #(
    .T_NUM(T), .LIFE_FRAMES(LIFE), .COOLDOWN_FRAMES(COOL), .REPEAT_FRAMES(REP)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .fire(fire), .vsync(vsync),
    .hit(hit), .launch(launch), .active(active), .free_cnt(free_cnt),
    .denied(denied)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a slot is in flight while its remaining frame count is > 0.
  int         m_life [T];
  int         m_cool = 0, m_rpt = 0;
  bit         m_req = 1'b0, m_fire_d = 1'b0;
  logic [3:0] e_launch = '0;
  logic       e_denied = 1'b0;

  function automatic logic [3:0] e_active();
    logic [3:0] a = '0;
    for (int i = 0; i < T; i++) a[i] = (m_life[i] > 0);
    return a;
  endfunction

  function automatic int e_free();
    int n = 0;
    for (int i = 0; i < T; i++) if (m_life[i] == 0) n++;
    return n;
  endfunction

  initial for (int i = 0; i < T; i++) m_life[i] = 0;

  always @(posedge clk) begin : model
    int tgt, c, nreq;
    if (!resetN) begin
      for (int i = 0; i < T; i++) m_life[i] = 0;
      m_cool = 0; m_rpt = 0; m_req = 1'b0; m_fire_d = 1'b0;
      e_launch = '0; e_denied = 1'b0;
    end else begin
      nreq = 0;
      if (fire && !m_fire_d && enable) begin
        nreq = 1; m_rpt = REP;
      end else if (!fire) begin
        m_rpt = 0;
      end else if (enable && vsync && REP != 0) begin
        if (m_rpt == 1) begin nreq = 1; m_rpt = REP; end
        else if (m_rpt > 0) m_rpt--;
      end
      c = m_cool;
      if (vsync && c > 0) c--;
      e_launch = '0; e_denied = 1'b0; tgt = -1;
      if (m_req && enable) begin
        if (c == 0) for (int i = T - 1; i >= 0; i--) if (m_life[i] == 0) tgt = i;
        if (tgt < 0) e_denied = 1'b1;
      end
      for (int i = 0; i < T; i++) begin
        if (m_life[i] > 0) begin
          if (hit[i]) m_life[i] = 0;
          else if (vsync) m_life[i]--;
        end
      end
      if (tgt >= 0) begin
        m_life[tgt] = LIFE; c = COOL; e_launch[tgt] = 1'b1;
      end
      m_cool = c; m_req = nreq[0]; m_fire_d = fire;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("launch", 32'(launch), 32'(e_launch));
      chk("denied", 32'(denied), 32'(e_denied));
      chk("active", 32'(active), 32'(e_active()));
      chk("free_cnt", 32'(free_cnt), 32'(e_free()));
    end
  end

  // Frames counted while slot 0 is in flight, checked at its first release.
  int v0 = 0;
  bit prev_a0 = 1'b0, life_done = 1'b0;
  always @(posedge clk) if (resetN && active[0] && vsync) v0++;
  always @(negedge clk) begin
    if (cmp_on && !life_done && prev_a0 && !active[0]) begin
      chk("slot0_life_frames", 32'(v0), 32'd90);
      life_done = 1'b1;
    end
    prev_a0 = active[0];
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    vsync = (cyc % FRAME == 0);
  endtask

  task automatic wait_vs(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (vsync) k++;
    end
  endtask

  task automatic shoot();
    fire = 1'b1;
    step();
    step();
  endtask

  initial begin : stim
    int n, nl, nd;
    resetN = 1'b0; enable = 1'b0; fire = 1'b0; hit = '0; vsync = 1'b0;
    step(); step();
    cmp_on = 1'b1;
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_free", 32'(free_cnt), 32'd4);
    chk("rst_launch", 32'(launch), 32'h0);
    chk("rst_denied", 32'(denied), 32'h0);
    resetN = 1'b1; enable = 1'b1;

    // Single shot
    while (cyc < 100) step();
    fire = 1'b1;
    step();
    chk("shot_req_cycle_launch", 32'(launch), 32'h0);
    step();
    chk("shot_launch", 32'(launch), 32'b0001);
    chk("shot_active", 32'(active), 32'b0001);
    chk("shot_free", 32'(free_cnt), 32'd3);
    fire = 1'b0;
    step();
    chk("shot_pulse_len", 32'(launch), 32'h0);

    // Cooldown: denied after 2 frames, accepted after 5
    wait_vs(2);
    shoot();
    chk("cool_denied", 32'(denied), 32'h1);
    chk("cool_no_launch", 32'(launch), 32'h0);
    fire = 1'b0;
    step();
    wait_vs(3);
    shoot();
    chk("cool_launch", 32'(launch), 32'b0010);
    chk("cool_active", 32'(active), 32'b0011);
    fire = 1'b0;

    // Fill all slots, then overflow
    wait_vs(5); shoot();
    chk("full_launch2", 32'(launch), 32'b0100);
    fire = 1'b0;
    wait_vs(5); shoot();
    chk("full_launch3", 32'(launch), 32'b1000);
    chk("full_free", 32'(free_cnt), 32'd0);
    fire = 1'b0;
    wait_vs(5); shoot();
    chk("full_denied", 32'(denied), 32'h1);
    chk("full_active", 32'(active), 32'b1111);
    fire = 1'b0;
    step();
    hit = 4'b0100;
    step();
    hit = '0;
    chk("hit_active", 32'(active), 32'b1011);
    chk("hit_free", 32'(free_cnt), 32'd1);
    wait_vs(5); shoot();
    chk("refill_launch", 32'(launch), 32'b0100);
    fire = 1'b0;

    // Hit coinciding with expiry of slot 1
    n = 0;
    do begin step(); n++; end while (!(m_life[1] == 1 && vsync) && n < 120 * FRAME);
    hit = 4'b0010;
    step();
    hit = '0;
    chk("hit_expiry_active", 32'(active), 32'b1100);
    chk("hit_expiry_free", 32'(free_cnt), 32'd2);

    // Enable low blocks requests; enable falling before arbitration drops silently
    enable = 1'b0;
    step();
    shoot();
    chk("dis_no_launch", 32'(launch), 32'h0);
    chk("dis_no_denied", 32'(denied), 32'h0);
    fire = 1'b0;
    step();
    enable = 1'b1;
    fire = 1'b1;
    step();
    enable = 1'b0;
    step();
    chk("fall_no_launch", 32'(launch), 32'h0);
    chk("fall_no_denied", 32'(denied), 32'h0);
    fire = 1'b0;
    n = 0;
    while (active != 4'b0000 && n < 100 * FRAME) begin step(); n++; end
    chk("dis_expired_active", 32'(active), 32'h0);
    chk("dis_expired_free", 32'(free_cnt), 32'd4);

    // Autofire: 45 frames held -> 4 launches then 1 denial
    enable = 1'b1;
    step();
    fire = 1'b1;
    nl = 0; nd = 0;
    for (int k = 0; k < 45 * FRAME; k++) begin
      step();
      if (launch != 4'b0000) nl++;
      if (denied) nd++;
    end
    chk("auto_launches", 32'(nl), 32'd4);
    chk("auto_denials", 32'(nd), 32'd1);
    chk("auto_active", 32'(active), 32'b1111);
    fire = 1'b0;
    step();

    // Reset mid-flight
    resetN = 1'b0;
    step();
    chk("midrst_active", 32'(active), 32'h0);
    chk("midrst_free", 32'(free_cnt), 32'd4);
    resetN = 1'b1;
    step();
    hit = 4'b1000;
    step();
    hit = '0;
    step();
    chk("idle_hit_active", 32'(active), 32'h0);
    chk("idle_hit_free", 32'(free_cnt), 32'd4);
    fire = 1'b1;
    step();
    resetN = 1'b0;
    step();
    chk("rst_cancel_launch", 32'(launch), 32'h0);
    chk("rst_cancel_active", 32'(active), 32'h0);
    fire = 1'b0;
    resetN = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
